// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for the F|D|E|M|W pipeline.
// Handles load-use stalls, taken-branch/jump squash and data-memory wait freeze.
// Drives the PC/stage-register write enables and per-stage flush lines.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned LU_STALLS   = 1,    // bubbles per load-use hazard (1..7)
    parameter int unsigned MEM_TIMEOUT = 255   // wait cycles before mem_timeout (1..255)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_writereg,
    input  logic        ex_branch_tkn,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_write,
    output logic        fd_write,
    output logic        de_write,
    output logic        em_write,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        flush_em,
    output logic        flush_mw,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StLuStall = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;

    // Remaining LU_STALL cycles after the detect cycle.
    localparam logic [2:0] LuInit    = 3'(LU_STALLS - 1);
    localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [1:0] saved_q, saved_d;       // state to resume when MEM_WAIT ends
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       lu_hazard;
    logic       mem_stall;
    logic [1:0] eff_state;

    // Hazard detection and the state whose rules apply this cycle.
    always_comb begin
        lu_hazard = ex_memread & ex_regwrite & (ex_writereg != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_writereg)) |
                     (id_uses_rt & (id_rt == ex_writereg)));
        mem_stall = mem_req & ~mem_ack;
        // On the ack cycle of a wait, the saved state's rules take over.
        eff_state = (state_q == StMemWait) ? saved_q : state_q;
    end

    // Priority-ordered output and next-state decode.
    always_comb begin
        state_d       = eff_state;
        saved_d       = saved_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = 8'd0;
        mem_timeout_d = mem_timeout_q;

        pc_write = 1'b1;
        fd_write = 1'b1;
        de_write = 1'b1;
        em_write = 1'b1;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        flush_em = 1'b0;
        flush_mw = 1'b0;

        if (mem_stall) begin
            // Freeze everything upstream of MEM and send a bubble to WB.
            pc_write = 1'b0;
            fd_write = 1'b0;
            de_write = 1'b0;
            em_write = 1'b0;
            flush_mw = 1'b1;
            state_d  = StMemWait;
            saved_d  = eff_state;
            if (wait_cnt_q != WaitLimit) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            if (wait_cnt_d == WaitLimit) begin
                mem_timeout_d = 1'b1;
            end
        end else if (ex_branch_tkn) begin
            // Squash IF and ID; also cancels any load-use stall in flight.
            flush_fd = 1'b1;
            flush_de = 1'b1;
            state_d  = StRun;
            lu_cnt_d = 3'd0;
        end else if (eff_state == StLuStall) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            flush_de = 1'b1;
            if (lu_cnt_q <= 3'd1) begin
                state_d  = StRun;
                lu_cnt_d = 3'd0;
            end else begin
                lu_cnt_d = lu_cnt_q - 3'd1;
            end
        end else if (lu_hazard) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            flush_de = 1'b1;
            if (LU_STALLS > 1) begin
                state_d  = StLuStall;
                lu_cnt_d = LuInit;
            end
        end else if (id_jump) begin
            flush_fd = 1'b1;
        end

        // Hold the whole pipeline inert while reset is asserted.
        if (reset) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            de_write = 1'b0;
            em_write = 1'b0;
            flush_fd = 1'b0;
            flush_de = 1'b0;
            flush_em = 1'b0;
            flush_mw = 1'b0;
        end
    end

    // FSM, stall counter, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            saved_q       <= StRun;
            lu_cnt_q      <= 3'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            lu_cnt_q      <= lu_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_fd) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LU_STALLS=1/MEM_TIMEOUT=4,
// one with LU_STALLS=3/MEM_TIMEOUT=255, sharing all inputs.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_writereg;
    logic        id_uses_rs, id_uses_rt, id_jump;
    logic        ex_memread, ex_regwrite, ex_branch_tkn;
    logic        mem_req, mem_ack;

    logic        pc_write1, fd_write1, de_write1, em_write1;
    logic        flush_fd1, flush_de1, flush_em1, flush_mw1, mem_timeout1;
    logic [31:0] stall_cycles1, flush_events1;
    logic        pc_write3, fd_write3, de_write3, em_write3;
    logic        flush_fd3, flush_de3, flush_em3, flush_mw3, mem_timeout3;
    logic [31:0] stall_cycles3, flush_events3;

    logic [7:0]  o1, o3;
    assign o1 = {pc_write1, fd_write1, de_write1, em_write1,
                 flush_fd1, flush_de1, flush_em1, flush_mw1};
    assign o3 = {pc_write3, fd_write3, de_write3, em_write3,
                 flush_fd3, flush_de3, flush_em3, flush_mw3};

    // {pc,fd,de,em,flush_fd,flush_de,flush_em,flush_mw}
    localparam logic [7:0] ZERO = 8'b0000_0000;
    localparam logic [7:0] NORM = 8'b1111_0000;
    localparam logic [7:0] LU   = 8'b0011_0100;
    localparam logic [7:0] BR   = 8'b1111_1100;
    localparam logic [7:0] JMP  = 8'b1111_1000;
    localparam logic [7:0] FRZ  = 8'b0000_0001;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [31:0] EXP_S1 = 32'd1, EXP_F1 = 32'd1, EXP_S3 = 32'd3, EXP_F3 = 32'd1;
`else
    localparam logic [31:0] EXP_S1 = 32'd0, EXP_F1 = 32'd0, EXP_S3 = 32'd0, EXP_F3 = 32'd0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALLS(1), .MEM_TIMEOUT(4)) u_dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_writereg(ex_writereg),
        .ex_branch_tkn(ex_branch_tkn), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write1), .fd_write(fd_write1), .de_write(de_write1),
        .em_write(em_write1), .flush_fd(flush_fd1), .flush_de(flush_de1),
        .flush_em(flush_em1), .flush_mw(flush_mw1), .mem_timeout(mem_timeout1),
        .stall_cycles(stall_cycles1), .flush_events(flush_events1)
    );

    pipe_hazard_ctrl #(.LU_STALLS(3), .MEM_TIMEOUT(255)) u_dut3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_writereg(ex_writereg),
        .ex_branch_tkn(ex_branch_tkn), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write3), .fd_write(fd_write3), .de_write(de_write3),
        .em_write(em_write3), .flush_fd(flush_fd3), .flush_de(flush_de3),
        .flush_em(flush_em3), .flush_mw(flush_mw3), .mem_timeout(mem_timeout3),
        .stall_cycles(stall_cycles3), .flush_events(flush_events3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_jump = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_writereg = 5'd0;
        ex_branch_tkn = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Load in EX writing r8, ID instruction reads r8 through rs.
    task automatic lu_rs8();
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd8;
        id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        settle();
        check("reset_outs1", o1, ZERO);
        check("reset_outs3", o3, ZERO);
        check("reset_tmo1", mem_timeout1, 1'b0);
        check("reset_stall_cnt1", stall_cycles1, 32'd0);

        // Reset in the middle of a memory wait.
        tick(); reset = 1'b0; mem_req = 1'b1; mem_ack = 1'b0;
        settle();
        check("mw_frz_1", o1, FRZ);
        for (int i = 2; i <= 5; i++) begin
            tick();
            settle();
            check($sformatf("mw_frz_%0d", i), o1, FRZ);
        end
        check("mw_tmo_before_reset", mem_timeout1, 1'b1);
        tick(); reset = 1'b1;
        settle();
        check("mw_reset_outs1", o1, ZERO);
        check("mw_reset_outs3", o3, ZERO);
        check("mw_reset_tmo1", mem_timeout1, 1'b0);
        tick(); reset = 1'b0; mem_req = 1'b0;
        settle();
        check("post_reset_run1", o1, NORM);
        check("post_reset_run3", o3, NORM);

        // Load-use: one bubble on dut1, three on dut3.
        tick(); lu_rs8();
        settle();
        check("lu1_detect", o1, LU);
        check("lu3_detect", o3, LU);
        tick(); idle();
        settle();
        check("lu1_release", o1, NORM);
        check("lu3_stall2", o3, LU);
        tick();
        settle();
        check("lu3_stall3", o3, LU);
        tick();
        settle();
        check("lu3_done", o3, NORM);

        // r0 destination never stalls; jump flushes IF/ID for one cycle.
        tick(); idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd0;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        settle();
        check("wr0_nostall1", o1, NORM);
        check("wr0_nostall3", o3, NORM);
        tick(); idle(); id_jump = 1'b1;
        settle();
        check("jump1", o1, JMP);
        check("jump3", o3, JMP);
        tick(); idle();
        settle();
        check("jump_one_cycle", o1, NORM);
        check("perf_stall1", stall_cycles1, EXP_S1);
        check("perf_flush1", flush_events1, EXP_F1);
        check("perf_stall3", stall_cycles3, EXP_S3);
        check("perf_flush3", flush_events3, EXP_F3);

        // Operand-use qualifiers and the rt path.
        tick(); idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd5;
        id_rs = 5'd5; id_rt = 5'd7; id_uses_rt = 1'b1;
        settle();
        check("no_use_rs", o1, NORM);
        tick(); ex_regwrite = 1'b0; id_uses_rs = 1'b1;
        settle();
        check("no_regwrite", o1, NORM);
        tick(); ex_regwrite = 1'b1; id_uses_rs = 1'b0; id_rt = 5'd5;
        settle();
        check("lu_rt1", o1, LU);
        tick(); idle();
        settle();
        check("lu_rt3_s2", o3, LU);
        tick();
        settle();
        check("lu_rt3_s3", o3, LU);
        tick();
        settle();
        check("lu_rt3_done", o3, NORM);

        // Taken branch on the second stall cycle aborts the stall.
        tick(); lu_rs8();
        settle();
        check("br_lu_detect3", o3, LU);
        tick(); idle(); ex_branch_tkn = 1'b1;
        settle();
        check("br_abort3", o3, BR);
        check("br_normal1", o1, BR);
        tick(); idle();
        settle();
        check("br_run_next3", o3, NORM);

        // Memory wait during a load-use stall resumes the stall afterwards.
        tick(); lu_rs8();
        settle();
        check("mwlu_detect3", o3, LU);
        tick(); idle(); mem_req = 1'b1;
        settle();
        check("mwlu_frz3", o3, FRZ);
        check("mwlu_frz1", o1, FRZ);
        tick(); mem_ack = 1'b1;
        settle();
        check("mwlu_resume3", o3, LU);
        check("mwlu_resume1", o1, NORM);
        tick(); idle();
        settle();
        check("mwlu_last3", o3, LU);
        tick();
        settle();
        check("mwlu_done3", o3, NORM);

        // Zero-wait access, then timeout after four wait cycles.
        tick(); idle(); mem_req = 1'b1; mem_ack = 1'b1;
        settle();
        check("zero_wait1", o1, NORM);
        for (int i = 1; i <= 6; i++) begin
            tick(); idle(); mem_req = 1'b1;
            settle();
            check($sformatf("tmo_frz_%0d", i), o1, FRZ);
            check($sformatf("tmo_flag_%0d", i), mem_timeout1, (i >= 5) ? 1'b1 : 1'b0);
        end
        tick(); mem_ack = 1'b1;
        settle();
        check("tmo_ack_run", o1, NORM);
        check("tmo_ack_flag", mem_timeout1, 1'b1);
        tick(); idle();
        settle();
        check("tmo_sticky1", mem_timeout1, 1'b1);
        check("tmo_none3", mem_timeout3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
